// File: rtl/fetch_stage.sv
// fetch_stage -- instruction fetch front end for a 16-bit pipeline.
//
// Sends the PC to instruction memory and delivers one instruction per cycle
// to the IF/ID register. Handles multi-cycle misses, hazard stalls (with a
// one-entry hold buffer), redirects from downstream branch resolution, and
// stops fetching after a HALT instruction.
//
// Ports
//   clk, rst          clock (rising edge), asynchronous active-low reset
//   stall_in          hazard hold: PC frozen, no new request
//   redirect_en/_pc   taken branch/jump target (bit 0 forced to 0)
//   imem_addr/_rd     memory request (address is always the PC)
//   imem_data/_done   memory response (done same cycle as rd on a hit)
//   IF_instr/IF_PC_2  instruction and its address + 2
//   IF_flush          IF/ID loads NOP 16'h0800
//   IF_nowrite        IF/ID holds (mirror of stall_in)
//   IF_HALT           IF_instr is a HALT (opcode 5'b00000)
//   halted            fetch stopped after HALT
//   bubble_cnt        bubble counter, only when FETCH_PERF_CNT_EN is defined
//
// Optional feature macro: FETCH_PERF_CNT_EN

module fetch_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_in,
  input  logic        redirect_en,
  input  logic [15:0] redirect_pc,
  output logic [15:0] imem_addr,
  output logic        imem_rd,
  input  logic [15:0] imem_data,
  input  logic        imem_done,
  output logic [15:0] IF_instr,
  output logic [15:0] IF_PC_2,
  output logic        IF_flush,
  output logic        IF_nowrite,
  output logic        IF_HALT,
  output logic        halted
`ifdef FETCH_PERF_CNT_EN
  ,output logic [15:0] bubble_cnt
`endif
);

  localparam logic [15:0] NOP = 16'h0800;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_WAIT   = 3'd1,
    S_DRAIN  = 3'd2,
    S_HOLD   = 3'd3,
    S_HALTED = 3'd4
  } state_t;

  state_t      state, state_nxt;
  logic [15:0] pc, pc_nxt, pc_inc, rpc;
  logic [15:0] buf_instr;
  logic        take;      // memory data delivered this cycle
  logic        use_buf;   // hold buffer delivered this cycle
  logic        buf_ld;

  assign pc_inc = pc + 16'd2;                 // wraps 16'hFFFE -> 16'h0000
  assign rpc    = redirect_pc & 16'hFFFE;

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    imem_rd   = 1'b0;
    take      = 1'b0;
    use_buf   = 1'b0;
    buf_ld    = 1'b0;
    case (state)
      S_FETCH: begin
        imem_rd = ~stall_in;
        if (redirect_en) begin
          pc_nxt = rpc;
          // a request that missed is still in flight: drain it
          if (imem_rd && !imem_done) state_nxt = S_DRAIN;
        end else if (imem_rd && imem_done) begin
          take      = 1'b1;
          pc_nxt    = pc_inc;
          state_nxt = (imem_data[15:11] == 5'b0) ? S_HALTED : S_FETCH;
        end else if (imem_rd) begin
          state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        imem_rd = 1'b1;
        if (redirect_en) begin
          pc_nxt    = rpc;
          state_nxt = imem_done ? S_FETCH : S_DRAIN;
        end else if (imem_done) begin
          take = 1'b1;
          if (stall_in) begin
            buf_ld    = 1'b1;
            state_nxt = S_HOLD;
          end else begin
            pc_nxt    = pc_inc;
            state_nxt = (imem_data[15:11] == 5'b0) ? S_HALTED : S_FETCH;
          end
        end
      end
      S_DRAIN: begin
        // last redirect seen while draining wins
        if (redirect_en) pc_nxt = rpc;
        if (imem_done) state_nxt = S_FETCH;
      end
      S_HOLD: begin
        if (redirect_en) begin
          pc_nxt    = rpc;
          state_nxt = S_FETCH;
        end else begin
          use_buf = 1'b1;
          if (!stall_in) begin
            pc_nxt    = pc_inc;
            state_nxt = (buf_instr[15:11] == 5'b0) ? S_HALTED : S_FETCH;
          end
        end
      end
      S_HALTED: begin
        if (redirect_en) begin
          pc_nxt    = rpc;
          state_nxt = S_FETCH;
        end
      end
      default: state_nxt = S_FETCH;
    endcase
    // reset already forces state/PC; outputs must also be quiet while held
    if (!rst) begin
      imem_rd = 1'b0;
      take    = 1'b0;
      use_buf = 1'b0;
      buf_ld  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_FETCH;
      pc        <= 16'h0000;
      buf_instr <= NOP;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
      if (buf_ld) buf_instr <= imem_data;
    end
  end

  assign imem_addr  = pc;
  assign IF_instr   = take ? imem_data : (use_buf ? buf_instr : NOP);
  assign IF_flush   = ~(take | use_buf);
  assign IF_HALT    = (take | use_buf) && (IF_instr[15:11] == 5'b0);
  assign IF_PC_2    = pc_inc;
  assign IF_nowrite = stall_in;
  assign halted     = (state == S_HALTED);

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      bubble_cnt <= 16'h0000;
    else if (IF_flush && state != S_HALTED && bubble_cnt != 16'hFFFF)
      bubble_cnt <= bubble_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage -- directed self-checking bench for fetch_stage.
// Inputs change just after the falling edge; outputs are checked 2 time
// units later, well before the next rising edge.

module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall_in, redirect_en, imem_done;
  logic [15:0] redirect_pc, imem_data;
  logic [15:0] imem_addr, IF_instr, IF_PC_2;
  logic        imem_rd, IF_flush, IF_nowrite, IF_HALT, halted;
`ifdef FETCH_PERF_CNT_EN
  logic [15:0] bubble_cnt;
`endif

  int checks = 0;
  int errors = 0;

  fetch_stage dut (
    .clk(clk), .rst(rst),
    .stall_in(stall_in), .redirect_en(redirect_en), .redirect_pc(redirect_pc),
    .imem_addr(imem_addr), .imem_rd(imem_rd),
    .imem_data(imem_data), .imem_done(imem_done),
    .IF_instr(IF_instr), .IF_PC_2(IF_PC_2), .IF_flush(IF_flush),
    .IF_nowrite(IF_nowrite), .IF_HALT(IF_HALT), .halted(halted)
`ifdef FETCH_PERF_CNT_EN
    ,.bubble_cnt(bubble_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // drive inputs for the current cycle and let combinational outputs settle
  task automatic drive(input logic st, input logic re, input logic [15:0] rp,
                       input logic dn, input logic [15:0] dt);
    stall_in = st; redirect_en = re; redirect_pc = rp; imem_done = dn; imem_data = dt;
    #2;
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b0;
    drive(0, 0, 16'h0, 1, 16'h5555);          // stray done during reset
    chk("rst_rd", imem_rd, 0);
    chk("rst_flush", IF_flush, 1);
    chk("rst_instr", IF_instr, 16'h0800);
    chk("rst_halted", halted, 0);
    chk("rst_addr", imem_addr, 16'h0000);
    chk("rst_ifhalt", IF_HALT, 0);

    // reset release, back-to-back hits
    @(negedge clk); rst = 1'b1;
    drive(0, 0, 16'h0, 1, 16'hA001);
    chk("h0_addr", imem_addr, 16'h0000);
    chk("h0_rd", imem_rd, 1);
    chk("h0_instr", IF_instr, 16'hA001);
    chk("h0_pc2", IF_PC_2, 16'h0002);
    chk("h0_flush", IF_flush, 0);
    cyc();
    drive(0, 0, 16'h0, 1, 16'hA002);
    chk("h1_addr", imem_addr, 16'h0002);
    chk("h1_pc2", IF_PC_2, 16'h0004);
    chk("h1_flush", IF_flush, 0);
    cyc();

    // 3-cycle miss at PC=4
    drive(0, 0, 16'h0, 0, 16'h0);
    chk("m0_addr", imem_addr, 16'h0004);
    chk("m0_flush", IF_flush, 1);
    chk("m0_instr", IF_instr, 16'h0800);
    cyc();
    drive(0, 0, 16'h0, 0, 16'h0);
    chk("m1_rd", imem_rd, 1);
    chk("m1_addr", imem_addr, 16'h0004);
    chk("m1_flush", IF_flush, 1);
    cyc();
    drive(0, 0, 16'h0, 1, 16'hA003);
    chk("m2_instr", IF_instr, 16'hA003);
    chk("m2_pc2", IF_PC_2, 16'h0006);
    chk("m2_flush", IF_flush, 0);
    cyc();
    drive(0, 0, 16'h0, 1, 16'hA004);
    chk("h6_addr", imem_addr, 16'h0006);
    cyc();

    // miss at PC=8, redirect while waiting -> drain
    drive(0, 0, 16'h0, 0, 16'h0);
    chk("r0_addr", imem_addr, 16'h0008);
    cyc();
    drive(0, 1, 16'h0041, 0, 16'h0);
    chk("r1_flush", IF_flush, 1);
    cyc();
    drive(0, 0, 16'h0, 0, 16'h0);
    chk("dr_rd", imem_rd, 0);
    chk("dr_flush", IF_flush, 1);
    cyc();
    drive(0, 0, 16'h0, 1, 16'hBEEF);
    chk("dr_discard", IF_instr, 16'h0800);
    chk("dr_discard_flush", IF_flush, 1);
    cyc();
    drive(0, 0, 16'h0, 1, 16'hA040);
    chk("rd_addr", imem_addr, 16'h0040);
    chk("rd_rd", imem_rd, 1);
    chk("rd_instr", IF_instr, 16'hA040);
    cyc();

    // stall in FETCH: no request, stray data ignored
    drive(1, 0, 16'h0, 1, 16'h7777);
    chk("sf_rd", imem_rd, 0);
    chk("sf_flush", IF_flush, 1);
    chk("sf_nowrite", IF_nowrite, 1);
    cyc();
    // redirect with a hit in FETCH: data dropped
    drive(0, 1, 16'h000A, 1, 16'h6666);
    chk("sf_addr", imem_addr, 16'h0042);
    chk("rf_flush", IF_flush, 1);
    cyc();

    // miss at PC=10, data returns under stall -> hold buffer
    drive(0, 0, 16'h0, 0, 16'h0);
    chk("s0_addr", imem_addr, 16'h000A);
    cyc();
    drive(1, 0, 16'h0, 1, 16'hB00A);
    chk("s1_instr", IF_instr, 16'hB00A);
    chk("s1_flush", IF_flush, 0);
    chk("s1_nowrite", IF_nowrite, 1);
    cyc();
    for (int i = 0; i < 2; i++) begin
      drive(1, 0, 16'h0, 0, 16'h0);
      chk("hold_instr", IF_instr, 16'hB00A);
      chk("hold_rd", imem_rd, 0);
      chk("hold_flush", IF_flush, 0);
      chk("hold_addr", imem_addr, 16'h000A);
      cyc();
    end
    drive(0, 0, 16'h0, 0, 16'h0);
    chk("rel_instr", IF_instr, 16'hB00A);
    chk("rel_pc2", IF_PC_2, 16'h000C);
    chk("rel_nowrite", IF_nowrite, 0);
    cyc();

    // hits 12..18 then HALT at 20
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 16'h0, 1, 16'hC00C + 16'(2 * i));
      chk("seq_addr", imem_addr, 16'h000C + 16'(2 * i));
      chk("seq_ifhalt", IF_HALT, 0);
      cyc();
    end
    drive(0, 0, 16'h0, 1, 16'h0000);
    chk("halt_addr", imem_addr, 16'h0014);
    chk("halt_if", IF_HALT, 1);
    chk("halt_flush", IF_flush, 0);
    cyc();
    for (int i = 0; i < 2; i++) begin
      drive(0, 0, 16'h0, 1, 16'h9999);
      chk("hd_halted", halted, 1);
      chk("hd_rd", imem_rd, 0);
      chk("hd_flush", IF_flush, 1);
      chk("hd_ifhalt", IF_HALT, 0);
      chk("hd_addr", imem_addr, 16'h0016);
      cyc();
    end
    drive(0, 1, 16'h0030, 0, 16'h0);
    chk("hr_flush", IF_flush, 1);
    cyc();
    drive(0, 0, 16'h0, 0, 16'h0);
    chk("hr_halted", halted, 0);
    chk("hr_addr", imem_addr, 16'h0030);
    chk("hr_rd", imem_rd, 1);
    cyc();

    // reset asserted mid-WAIT
    rst = 1'b0;
    drive(0, 0, 16'h0, 1, 16'h4444);
    chk("rw_rd", imem_rd, 0);
    chk("rw_flush", IF_flush, 1);
    chk("rw_instr", IF_instr, 16'h0800);
    chk("rw_addr", imem_addr, 16'h0000);
    cyc();
    rst = 1'b1;
    drive(0, 0, 16'h0, 1, 16'hD000);
    chk("rr_addr", imem_addr, 16'h0000);
    chk("rr_rd", imem_rd, 1);
    chk("rr_instr", IF_instr, 16'hD000);
    chk("rr_pc2", IF_PC_2, 16'h0002);
    cyc();

    // PC wrap at 16'hFFFE (odd target bit dropped)
    drive(0, 1, 16'hFFFF, 1, 16'h1111);
    chk("w_flush", IF_flush, 1);
    cyc();
    drive(0, 0, 16'h0, 1, 16'hE0FE);
    chk("w_addr", imem_addr, 16'hFFFE);
    chk("w_pc2", IF_PC_2, 16'h0000);
    cyc();

    // redirect in WAIT coincident with done: straight back to FETCH
    drive(0, 0, 16'h0, 0, 16'h0);
    chk("wr_addr", imem_addr, 16'h0000);
    cyc();
    drive(0, 1, 16'h0050, 1, 16'h2222);
    chk("wr_flush", IF_flush, 1);
    cyc();
    drive(0, 0, 16'h0, 1, 16'h1234);
    chk("wr_new_addr", imem_addr, 16'h0050);
    chk("wr_new_rd", imem_rd, 1);
    chk("wr_new_instr", IF_instr, 16'h1234);
    cyc();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Ports SHALL be (clock and reset first):
- clk  in  1  sole clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- stall_in  in  1  hazard-unit hold; freezes PC, no new request.
- redirect_en  in  1  taken branch/jump resolved downstream.
- redirect_pc  in  16  redirect target (bit 0 ignored, treated 0).
- imem_addr  out  16  instruction memory/cache address (= PC).
- imem_rd  out  1  read request.
- imem_data  in  16  returned instruction, valid when imem_done=1.
- imem_done  in  1  read completes this cycle (hit: same cycle as imem_rd).
- IF_instr  out  16  instruction to IF/ID register.
- IF_PC_2  out  16  address of IF_instr + 2.
- IF_flush  out  1  IF/ID SHALL load NOP 16'h0800.
- IF_nowrite  out  1  IF/ID SHALL hold; equals stall_in.
- IF_HALT  out  1  IF_instr is HALT (opcode bits[15:11]=5'b00000).
- halted  out  1  fetch stopped after HALT.
- bubble_cnt  out  16  present only with FETCH_PERF_CNT_EN.

Function
REQ-002 States SHALL be FETCH, WAIT, DRAIN, HOLD, HALTED; reset state FETCH.
REQ-003 FETCH: imem_rd=1 unless stall_in; imem_done=1 -> instruction valid this cycle; imem_done=0 -> WAIT next cycle.
REQ-004 WAIT: imem_rd=1, address held; imem_done=1 -> instruction valid, then FETCH.
REQ-005 Valid instruction: IF_instr=imem_data, IF_PC_2=PC+2, IF_flush=0; PC<=PC+2 (mod 2^16, wraps 16'hFFFE->16'h0000).
REQ-006 No valid instruction in a cycle: IF_instr=16'h0800, IF_flush=1, IF_HALT=0.
REQ-007 Valid instruction with stall_in=1: captured in 1-entry buffer, state HOLD, PC not advanced; HOLD drives buffered instruction with IF_flush=0, imem_rd=0; stall_in=0 -> PC<=PC+2, FETCH.
REQ-008 redirect_en=1 SHALL force IF_flush=1 that cycle, PC<=redirect_pc, buffer cleared; priority over stall_in and halt.
REQ-009 redirect_en in WAIT with imem_done=0: state DRAIN, imem_rd=0; returning data discarded (IF_flush=1); DRAIN exits to FETCH on imem_done, first request at redirect_pc.
REQ-010 redirect_en in WAIT coincident with imem_done: data discarded, FETCH at redirect_pc next cycle, no DRAIN.
REQ-011 Valid HALT instruction SHALL pass once with IF_HALT=1, then state HALTED: imem_rd=0, PC frozen, halted=1, IF_flush=1.
REQ-012 HALTED exits only on redirect_en (to FETCH at redirect_pc, halted=0).
REQ-013 Multiple redirects in DRAIN: last redirect_pc SHALL win.

Reset
REQ-014 rst=0 SHALL immediately: PC=16'h0000, state FETCH, buffer empty, imem_rd=0, halted=0, bubble_cnt=0, IF_flush=1, IF_instr=16'h0800.
REQ-015 Reset mid-WAIT/DRAIN SHALL abandon the access; first post-reset imem_done without a new request is ignored.
REQ-016 First request SHALL be issued the first rising edge after rst deasserts, address 16'h0000.

Configuration
REQ-017 Macro FETCH_PERF_CNT_EN defined: bubble_cnt SHALL increment (saturating at 16'hFFFF) each cycle IF_flush=1 and not HALTED, not reset.
REQ-018 Macro undefined: bubble_cnt port and counter SHALL be absent; all other behaviour identical.

Verification
REQ-019 Reset release, imem_done=1 each cycle, data 16'hA001,16'hA002 -> IF_PC_2=2,4, IF_flush=0, imem_addr 0,2,4.
REQ-020 3-cycle miss at PC=4 -> 2 cycles IF_instr=16'h0800 with IF_flush=1, then data, PC=6; bubble_cnt=2 if enabled.
REQ-021 Miss at PC=8, redirect_en to 16'h0040 in WAIT, done 2 cycles later -> data discarded, next imem_addr=16'h0040.
REQ-022 stall_in=1 for 3 cycles on hit at PC=10 -> IF_nowrite=1, IF_instr held, no imem_rd, PC=12 after release.
REQ-023 HALT (16'h0000) at PC=20 -> IF_HALT=1 one cycle, halted=1, imem_rd=0; redirect to 16'h0030 resumes fetch.
REQ-024 rst=0 during WAIT -> outputs at reset values same cycle, fetch restarts at 0.
